lcb_responder: RTL and testbench
================================

Name: lcb_responder

Overview:
- Emulates the slave end of the LCB RS-485 request/response link, so the frame former can be bench-tested and loop-tested on hardware without a real commutation block.
- Receives the fixed-length request frame as bytes from a UART receiver and validates its sync byte and checksum.
- On a valid frame, turns the bus around and transmits a response frame of 12-bit samples, read from a sample memory addressed by the requested cycle number.
- Sits between an RX byte deserialiser and a TX byte serialiser, both running at the clk domain.

Parameters:
- REQ_BYTES, 14: request frame length in bytes, including sync and checksum; legal range 3..31.
- RSP_WORDS, 12: number of 12-bit samples per response; legal range 1..16.
- SYNC, 8'h55: first byte of every request and every response.
- TIMEOUT, 800: maximum number of idle clk cycles allowed between request bytes.
- TURNAROUND, 80: clk cycles from request accepted to dir_tx asserted, and from dir_tx asserted to the first tx_load.
- GUARD, 80: clk cycles dir_tx is held after the final byte completes.

Ports:
- clk  in  1  system clock (80 MHz)
- reset  in  1  asynchronous, active-low reset
- rx_data  in  8  received byte
- rx_valid  in  1  level; rx_data is valid while high; a byte is accepted on its rising edge only
- tx_data  out  8  byte to transmit
- tx_load  out  1  one-cycle pulse starting transmission of tx_data
- tx_ready  in  1  serialiser idle; drops no later than 1 cycle after tx_load
- dir_tx  out  1  RS-485 driver enable
- dir_rx  out  1  RS-485 receiver enable; always equals ~dir_tx
- smp_addr  out  9  sample memory address = {cycle[4:0], word_idx[3:0]}
- smp_rden  out  1  sample memory read enable
- smp_data  in  12  sample; valid 2 cycles after smp_rden (registered-address ROM with registered output)
- cycle_num  out  5  cycle field of the last accepted request
- frame_ok  out  1  one-cycle pulse when a request is accepted
- frame_err  out  1  one-cycle pulse on bad checksum or timeout

Behaviour:
- Reset values: tx_data=0, tx_load=0, dir_tx=0, dir_rx=1, smp_addr=0, smp_rden=0, cycle_num=0, frame_ok=0, frame_err=0; FSM in HUNT; all counters 0.
- Byte strobe: registered edge detect of rx_valid; strobe = rx_valid & ~rx_valid_d. A level held for many cycles counts as one byte.
- States:
  - HUNT: ignore every byte except SYNC. On SYNC: byte_cnt=1, sum=SYNC, go to RECV.
  - RECV: on each strobe, accumulate sum (8-bit, mod 256) over bytes 0..REQ_BYTES-2. Byte 1 bits [4:0] are latched as the cycle; bits [7:5] are ignored. Byte REQ_BYTES-1 is the checksum; on it go to CHECK. Any gap of TIMEOUT cycles without a strobe -> frame_err pulse, go to HUNT. A SYNC value arriving mid-frame is data, not a restart.
  - CHECK (1 cycle): checksum == sum -> frame_ok pulse, cycle_num updated, go to TURN. Otherwise frame_err pulse, go to HUNT, cycle_num unchanged.
  - TURN: wait TURNAROUND cycles, assert dir_tx, wait a further TURNAROUND cycles, then go to SEND.
  - SEND: byte order is SYNC, {3'b0,cycle}, then for each word w[0..RSP_WORDS-1] {4'h0,w[11:8]} followed by w[7:0], then checksum. The checksum is the 8-bit sum of all preceding response bytes. Total bytes = 3 + 2*RSP_WORDS.
    - Each byte: wait tx_ready=1, drive tx_data and pulse tx_load, ignore tx_ready for the next cycle, repeat.
    - Sample fetch: smp_rden pulses with smp_addr={cycle,idx}. The word is captured 2 cycles later, before its high byte is loaded. The fetch may overlap the previous byte's transmission.
  - GUARD: after the checksum byte's tx_load, wait tx_ready=1, then GUARD cycles, drop dir_tx, go to HUNT.
- Strobes during TURN, SEND or GUARD are discarded. Half-duplex echo is expected, so these bytes are never counted and never flagged.
- Reset mid-operation: all outputs return to reset values immediately; dir_tx drops asynchronously.
- No back-to-back response: a new request is only recognised once the FSM is in HUNT.

Test Plan:
- Valid request: 55,03, eleven bytes 00, checksum 58; memory word at {3,i} = 12'hA00+i. Expected: frame_ok, cycle_num=3, response 55,03,0A,00,0A,01,…,0A,0B, checksum correct; 27 tx_load pulses total.
- Bad checksum: same frame with last byte 59. Expected: frame_err pulse, no tx_load, dir_tx stays 0, cycle_num unchanged.
- Timeout: send 5 bytes, idle 801 cycles, then a full valid frame. Expected: one frame_err, then a normal response to the second frame.
- Garbage before sync: bytes 00,FF,55(sync),… valid frame. Expected: leading bytes ignored, frame accepted; a 55 at byte position 4 is treated as data.
- Level rx_valid held 20 cycles per byte, plus echo bytes injected during SEND. Expected: one byte counted per assertion, echoes ignored, response unchanged.
- Reset asserted during SEND byte 5. Expected: dir_tx=0 immediately, FSM in HUNT; the next valid frame gets a full response.

Source files
------------

// File: rtl/lcb_responder_if.sv
// Signal bundle between the LCB responder and its surroundings: byte links, bus direction,
// sample memory port and request status.
interface lcb_responder_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_load;
  logic        tx_ready;
  logic        dir_tx;
  logic        dir_rx;
  logic [8:0]  smp_addr;
  logic        smp_rden;
  logic [11:0] smp_data;
  logic [4:0]  cycle_num;
  logic        frame_ok;
  logic        frame_err;

  // Responder side of the link.
  modport slave (
    input  rx_data, rx_valid, tx_ready, smp_data,
    output tx_data, tx_load, dir_tx, dir_rx, smp_addr, smp_rden,
           cycle_num, frame_ok, frame_err
  );

  // Environment side: deserialiser, serialiser, sample memory, monitor.
  modport master (
    output rx_data, rx_valid, tx_ready, smp_data,
    input  tx_data, tx_load, dir_tx, dir_rx, smp_addr, smp_rden,
           cycle_num, frame_ok, frame_err
  );
endinterface

// File: rtl/lcb_responder.sv
// LCB link slave emulator: validates fixed-length requests and answers with a frame of
// 12-bit samples read from a sample memory, driving the RS-485 direction around it.
module lcb_responder #(
  parameter int unsigned REQ_BYTES  = 14,
  parameter int unsigned RSP_WORDS  = 12,
  parameter logic [7:0]  SYNC       = 8'h55,
  parameter int unsigned TIMEOUT    = 800,
  parameter int unsigned TURNAROUND = 80,
  parameter int unsigned GUARD      = 80
) (
  input  logic           clk,
  input  logic           reset,
  lcb_responder_if.slave bus
);

  localparam int unsigned   CW       = 16;
  localparam int unsigned   TX_BYTES = 3 + 2 * RSP_WORDS;
  localparam logic [4:0]    REQ_LAST = 5'(REQ_BYTES - 1);
  localparam logic [5:0]    TX_LAST  = 6'(TX_BYTES - 1);
  localparam logic [4:0]    WORDS    = 5'(RSP_WORDS);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] TA_LAST  = CW'(TURNAROUND - 1);
  localparam logic [CW-1:0] TA_PRE   = CW'(TURNAROUND - 2);
  localparam logic [CW-1:0] GD_LAST  = CW'(GUARD - 1);

  typedef enum logic [2:0] {
    S_HUNT, S_RECV, S_CHECK, S_TURN, S_SEND, S_DRAIN, S_GUARD
  } state_e;

  function automatic logic [7:0] sum8(input logic [7:0] a, input logic [7:0] b);
    return a + b;
  endfunction

  state_e        state_q, state_d;
  logic          rx_valid_q, rx_valid_d;
  logic [4:0]    byte_cnt_q, byte_cnt_d;
  logic [7:0]    sum_q, sum_d;
  logic [7:0]    chk_q, chk_d;
  logic [4:0]    cyc_q, cyc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    cycle_num_q, cycle_num_d;
  logic          frame_ok_q, frame_ok_d;
  logic          frame_err_q, frame_err_d;
  logic          dir_tx_q, dir_tx_d;
  logic          dir_rx_q, dir_rx_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_load_q, tx_load_d;
  logic          tx_hold_q, tx_hold_d;
  logic [5:0]    tx_idx_q, tx_idx_d;
  logic [7:0]    tx_sum_q, tx_sum_d;
  logic [4:0]    fetch_idx_q, fetch_idx_d;
  logic [8:0]    smp_addr_q, smp_addr_d;
  logic          smp_rden_q, smp_rden_d;
  logic          rd1_q, rd1_d;
  logic          rd2_q, rd2_d;
  logic [11:0]   word_q, word_d;
  logic          word_vld_q, word_vld_d;

  logic          strobe_s;
  logic          tx_go_s;
  logic          fetch_go_s;
  logic [7:0]    tx_byte_s;
  logic          byte_rdy_s;
  logic          low_byte_s;

  // Next-state, datapath and output computation for the whole request/response sequence.
  always_comb begin
    state_d     = state_q;
    rx_valid_d  = bus.rx_valid;
    byte_cnt_d  = byte_cnt_q;
    sum_d       = sum_q;
    chk_d       = chk_q;
    cyc_d       = cyc_q;
    cnt_d       = cnt_q;
    cycle_num_d = cycle_num_q;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    dir_tx_d    = dir_tx_q;
    tx_data_d   = tx_data_q;
    tx_load_d   = 1'b0;
    tx_hold_d   = tx_load_q;
    tx_idx_d    = tx_idx_q;
    tx_sum_d    = tx_sum_q;
    fetch_idx_d = fetch_idx_q;
    smp_addr_d  = smp_addr_q;
    smp_rden_d  = 1'b0;
    rd1_d       = smp_rden_q;
    rd2_d       = rd1_q;
    word_d      = word_q;
    word_vld_d  = word_vld_q;

    strobe_s   = bus.rx_valid & ~rx_valid_q;
    // The serialiser's ready is stale for the load cycle and the one after it.
    tx_go_s    = bus.tx_ready & ~tx_load_q & ~tx_hold_q;
    fetch_go_s = ~word_vld_q & ~smp_rden_q & ~rd1_q & ~rd2_q & (fetch_idx_q < WORDS);
    low_byte_s = 1'b0;
    byte_rdy_s = 1'b1;

    if (tx_idx_q == 6'd0) begin
      tx_byte_s = SYNC;
    end else if (tx_idx_q == 6'd1) begin
      tx_byte_s = {3'b000, cycle_num_q};
    end else if (tx_idx_q == TX_LAST) begin
      tx_byte_s = tx_sum_q;
    end else if (tx_idx_q[0] == 1'b0) begin
      tx_byte_s  = {4'h0, word_q[11:8]};
      byte_rdy_s = word_vld_q;
    end else begin
      tx_byte_s  = word_q[7:0];
      byte_rdy_s = word_vld_q;
      low_byte_s = 1'b1;
    end

    if (rd2_q) begin
      word_d     = bus.smp_data;
      word_vld_d = 1'b1;
    end else begin
      word_d     = word_q;
    end

    case (state_q)
      S_HUNT: begin
        if (strobe_s && (bus.rx_data == SYNC)) begin
          byte_cnt_d = 5'd1;
          sum_d      = SYNC;
          cnt_d      = '0;
          state_d    = S_RECV;
        end else begin
          byte_cnt_d = 5'd0;
        end
      end
      S_RECV: begin
        if (strobe_s) begin
          cnt_d = '0;
          if (byte_cnt_q == REQ_LAST) begin
            chk_d   = bus.rx_data;
            state_d = S_CHECK;
          end else begin
            sum_d      = sum8(sum_q, bus.rx_data);
            byte_cnt_d = byte_cnt_q + 5'd1;
            if (byte_cnt_q == 5'd1) begin
              cyc_d = bus.rx_data[4:0];
            end else begin
              cyc_d = cyc_q;
            end
          end
        end else if (cnt_q == TO_LAST) begin
          frame_err_d = 1'b1;
          byte_cnt_d  = 5'd0;
          state_d     = S_HUNT;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_CHECK: begin
        byte_cnt_d = 5'd0;
        cnt_d      = '0;
        if (chk_q == sum_q) begin
          frame_ok_d  = 1'b1;
          cycle_num_d = cyc_q;
          state_d     = S_TURN;
        end else begin
          frame_err_d = 1'b1;
          state_d     = S_HUNT;
        end
      end
      S_TURN: begin
        if (!dir_tx_q) begin
          if (cnt_q == TA_LAST) begin
            dir_tx_d = 1'b1;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        // Leave one cycle early: the first tx_load is registered out of SEND.
        end else if (cnt_q == TA_PRE) begin
          tx_idx_d    = 6'd0;
          tx_sum_d    = 8'h00;
          fetch_idx_d = 5'd0;
          word_vld_d  = 1'b0;
          state_d     = S_SEND;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_SEND: begin
        if (fetch_go_s) begin
          smp_rden_d  = 1'b1;
          smp_addr_d  = {cycle_num_q, fetch_idx_q[3:0]};
          fetch_idx_d = fetch_idx_q + 5'd1;
        end else begin
          smp_addr_d = smp_addr_q;
        end
        if (tx_go_s && byte_rdy_s) begin
          tx_data_d = tx_byte_s;
          tx_load_d = 1'b1;
          tx_sum_d  = sum8(tx_sum_q, tx_byte_s);
          if (low_byte_s) begin
            word_vld_d = 1'b0;
          end else begin
            word_vld_d = word_vld_q;
          end
          if (tx_idx_q == TX_LAST) begin
            state_d = S_DRAIN;
          end else begin
            tx_idx_d = tx_idx_q + 6'd1;
          end
        end else begin
          tx_data_d = tx_data_q;
        end
      end
      S_DRAIN: begin
        if (tx_go_s) begin
          cnt_d   = '0;
          state_d = S_GUARD;
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_GUARD: begin
        if (cnt_q == GD_LAST) begin
          dir_tx_d = 1'b0;
          state_d  = S_HUNT;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        dir_tx_d = 1'b0;
        state_d  = S_HUNT;
      end
    endcase

    dir_rx_d = ~dir_tx_d;
  end

  // State and output registers; reset drops the bus driver immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_HUNT;
      rx_valid_q  <= 1'b0;
      byte_cnt_q  <= 5'd0;
      sum_q       <= 8'h00;
      chk_q       <= 8'h00;
      cyc_q       <= 5'd0;
      cnt_q       <= '0;
      cycle_num_q <= 5'd0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      dir_tx_q    <= 1'b0;
      dir_rx_q    <= 1'b1;
      tx_data_q   <= 8'h00;
      tx_load_q   <= 1'b0;
      tx_hold_q   <= 1'b0;
      tx_idx_q    <= 6'd0;
      tx_sum_q    <= 8'h00;
      fetch_idx_q <= 5'd0;
      smp_addr_q  <= 9'd0;
      smp_rden_q  <= 1'b0;
      rd1_q       <= 1'b0;
      rd2_q       <= 1'b0;
      word_q      <= 12'h000;
      word_vld_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_valid_q  <= rx_valid_d;
      byte_cnt_q  <= byte_cnt_d;
      sum_q       <= sum_d;
      chk_q       <= chk_d;
      cyc_q       <= cyc_d;
      cnt_q       <= cnt_d;
      cycle_num_q <= cycle_num_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      dir_tx_q    <= dir_tx_d;
      dir_rx_q    <= dir_rx_d;
      tx_data_q   <= tx_data_d;
      tx_load_q   <= tx_load_d;
      tx_hold_q   <= tx_hold_d;
      tx_idx_q    <= tx_idx_d;
      tx_sum_q    <= tx_sum_d;
      fetch_idx_q <= fetch_idx_d;
      smp_addr_q  <= smp_addr_d;
      smp_rden_q  <= smp_rden_d;
      rd1_q       <= rd1_d;
      rd2_q       <= rd2_d;
      word_q      <= word_d;
      word_vld_q  <= word_vld_d;
    end
  end

  assign bus.tx_data   = tx_data_q;
  assign bus.tx_load   = tx_load_q;
  assign bus.dir_tx    = dir_tx_q;
  assign bus.dir_rx    = dir_rx_q;
  assign bus.smp_addr  = smp_addr_q;
  assign bus.smp_rden  = smp_rden_q;
  assign bus.cycle_num = cycle_num_q;
  assign bus.frame_ok  = frame_ok_q;
  assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_lcb_responder.sv
// Directed bench for lcb_responder: request frames in, response bytes and timing checked
// against a frame-level model of the response.
module tb_lcb_responder;
  localparam int TA = 80;
  localparam int GD = 80;
  localparam int NB = 27;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  lcb_responder_if bus();

  lcb_responder dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int tot = 0;
  int bad = 0;
  logic [7:0] exp_q[$];
  logic [4:0] exp_cycle = 5'd0;
  logic [7:0] frm [14];
  int cyc = 0, t_ok = 0, t_rise = 0, t_g = -1;
  int ok_cnt = 0, err_cnt = 0, rise_cnt = 0, load_cnt = 0;
  int rsp_idx = 0, fetch_i = 0, done_cnt = 0;
  bit last_seen = 1'b0;
  bit dir_prev = 1'b0;
  int ser_cnt = 0;
  logic [8:0] rom_a = 9'd0;
  logic rom_v = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tot++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [11:0] mem_word(input logic [8:0] a);
    if (a[8:4] == 5'd3) return 12'hA00 + {8'h00, a[3:0]};
    return {3'b101, a[8:4], a[3:0]};
  endfunction

  // Expected response: SYNC, cycle, hi/lo of each sample, then 8-bit sum of all of those.
  function automatic void build_rsp(input logic [4:0] c);
    logic [7:0] s;
    logic [11:0] w;
    exp_q.delete();
    exp_q.push_back(8'h55);
    exp_q.push_back({3'b000, c});
    s = 8'h55 + {3'b000, c};
    for (int i = 0; i < 12; i++) begin
      w = mem_word({c, 4'(i)});
      exp_q.push_back({4'h0, w[11:8]});
      exp_q.push_back(w[7:0]);
      s = s + {4'h0, w[11:8]} + w[7:0];
    end
    exp_q.push_back(s);
  endfunction

  function automatic void build_req(input logic [7:0] b1, input bit data55);
    logic [7:0] s;
    frm[0] = 8'h55;
    frm[1] = b1;
    for (int i = 2; i < 13; i++) frm[i] = 8'h00;
    if (data55) frm[4] = 8'h55;
    s = 8'h00;
    for (int i = 0; i < 13; i++) s = s + frm[i];
    frm[13] = s;
  endfunction

  task automatic new_rsp(input logic [4:0] c);
    build_rsp(c);
    exp_cycle = c;
    rsp_idx = 0;
    fetch_i = 0;
  endtask

  // Sample memory: registered address, registered data.
  always @(posedge clk) begin
    rom_a <= bus.smp_addr;
    rom_v <= bus.smp_rden;
    if (rom_v) bus.smp_data <= mem_word(rom_a);
  end

  // Serialiser: busy for 12 cycles after each load.
  always @(posedge clk) begin
    if (bus.tx_load) ser_cnt <= 12;
    else if (ser_cnt != 0) ser_cnt <= ser_cnt - 1;
  end
  assign bus.tx_ready = (ser_cnt == 0);

  // Per-cycle comparison of DUT outputs against the response model and timing rules.
  always @(negedge clk) begin
    if (!rst_n) begin
      dir_prev = 1'b0;
    end else begin
      cyc++;
      chk("dir_rx", 32'(bus.dir_rx), 32'(!bus.dir_tx));
      if (bus.frame_ok) begin
        ok_cnt++;
        t_ok = cyc;
        chk("cycle_num_at_ok", 32'(bus.cycle_num), 32'(exp_cycle));
      end
      if (bus.frame_err) err_cnt++;
      if (bus.dir_tx && !dir_prev) begin
        rise_cnt++;
        t_rise = cyc;
        chk("turn_to_dir", cyc - t_ok, TA);
      end
      if (bus.tx_load) begin
        chk("load_with_dir", 32'(bus.dir_tx), 32'd1);
        if (rsp_idx == 0) chk("dir_to_load", cyc - t_rise, TA);
        if (exp_q.size() == 0) begin
          tot++;
          bad++;
          $display("FAIL extra_load at %0t: got byte %0h expected none", $time, bus.tx_data);
        end else begin
          chk("tx_byte", 32'(bus.tx_data), 32'(exp_q.pop_front()));
          if (exp_q.size() == 0) last_seen = 1'b1;
        end
        rsp_idx++;
        load_cnt++;
      end
      if (last_seen && t_g < 0 && bus.tx_ready && !bus.tx_load) t_g = cyc;
      if (!bus.dir_tx && dir_prev) begin
        chk("guard_len", cyc - t_g, GD + 1);
        done_cnt++;
        last_seen = 1'b0;
        t_g = -1;
      end
      if (bus.smp_rden) begin
        chk("smp_addr", 32'(bus.smp_addr), 32'({exp_cycle, 4'(fetch_i)}));
        fetch_i++;
      end
      dir_prev = bus.dir_tx;
    end
  end

  task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
    @(posedge clk); #1;
    bus.rx_data = b;
    bus.rx_valid = 1'b1;
    repeat (hold) @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  task automatic send_frame(input int n, input int hold, input int gap);
    for (int i = 0; i < n; i++) send_byte(frm[i], hold, gap);
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 4000 && done_cnt < target; i++) @(posedge clk);
    #1;
    chk("response_done", done_cnt, target);
  endtask

  task automatic wait_idx(input int n);
    for (int i = 0; i < 3000 && rsp_idx < n; i++) @(posedge clk);
    #1;
    chk("reach_byte", 32'(rsp_idx >= n), 32'd1);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_tx_data"}, 32'(bus.tx_data), 32'd0);
    chk({tag, "_tx_load"}, 32'(bus.tx_load), 32'd0);
    chk({tag, "_dir_tx"}, 32'(bus.dir_tx), 32'd0);
    chk({tag, "_dir_rx"}, 32'(bus.dir_rx), 32'd1);
    chk({tag, "_smp_addr"}, 32'(bus.smp_addr), 32'd0);
    chk({tag, "_smp_rden"}, 32'(bus.smp_rden), 32'd0);
    chk({tag, "_cycle_num"}, 32'(bus.cycle_num), 32'd0);
    chk({tag, "_frame_ok"}, 32'(bus.frame_ok), 32'd0);
    chk({tag, "_frame_err"}, 32'(bus.frame_err), 32'd0);
  endtask

  initial begin
    bus.rx_data = 8'h00;
    bus.rx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("rst");
    rst_n = 1'b1;

    // Valid request for cycle 3; pin the model with hand-computed values.
    build_req(8'h03, 1'b0);
    chk("model_req_chk", 32'(frm[13]), 32'h58);
    new_rsp(5'd3);
    chk("model_rsp_len", exp_q.size(), NB);
    chk("model_rsp_b2", 32'(exp_q[2]), 32'h0A);
    chk("model_rsp_b25", 32'(exp_q[25]), 32'h0B);
    chk("model_rsp_sum", 32'(exp_q[26]), 32'h12);
    send_frame(14, 1, 2);
    wait_done(1);
    chk("t1_ok_cnt", ok_cnt, 1);
    chk("t1_cycle_num", 32'(bus.cycle_num), 32'd3);
    chk("t1_loads", load_cnt, 27);
    chk("t1_left", exp_q.size(), 0);

    // Bad checksum: error pulse, no response, cycle unchanged.
    build_req(8'h09, 1'b0);
    frm[13] = frm[13] ^ 8'h01;
    send_frame(14, 1, 2);
    repeat (300) @(posedge clk);
    #1;
    chk("t2_err_cnt", err_cnt, 1);
    chk("t2_loads", load_cnt, 27);
    chk("t2_rises", rise_cnt, 1);
    chk("t2_cycle_num", 32'(bus.cycle_num), 32'd3);
    chk("t2_dir_tx", 32'(bus.dir_tx), 32'd0);

    // Timeout after five bytes, then a full frame.
    build_req(8'h05, 1'b0);
    send_frame(5, 1, 0);
    repeat (790) @(posedge clk);
    #1;
    chk("t3_no_early_timeout", err_cnt, 1);
    repeat (15) @(posedge clk);
    #1;
    chk("t3_err_cnt", err_cnt, 2);
    new_rsp(5'd5);
    send_frame(14, 1, 2);
    wait_done(2);
    chk("t3_ok_cnt", ok_cnt, 2);
    chk("t3_cycle_num", 32'(bus.cycle_num), 32'd5);

    // Garbage before sync and a SYNC-valued data byte at position 4.
    send_byte(8'h00, 1, 2);
    send_byte(8'hFF, 1, 2);
    build_req(8'h03, 1'b1);
    chk("model_req_chk55", 32'(frm[13]), 32'hAD);
    new_rsp(5'd3);
    send_frame(14, 1, 2);
    wait_done(3);
    chk("t4_ok_cnt", ok_cnt, 3);
    chk("t4_err_cnt", err_cnt, 2);

    // Level rx_valid held 20 cycles per byte; echo bytes injected during SEND.
    build_req(8'hF1, 1'b0);
    new_rsp(5'd17);
    send_frame(14, 20, 5);
    wait_idx(3);
    send_byte(8'h55, 3, 3);
    send_byte(8'hF1, 3, 3);
    send_byte(8'h00, 3, 3);
    send_byte(8'h55, 3, 3);
    wait_done(4);
    chk("t5_ok_cnt", ok_cnt, 4);
    chk("t5_err_cnt", err_cnt, 2);
    chk("t5_cycle_num", 32'(bus.cycle_num), 32'd17);
    chk("t5_loads", load_cnt, 108);

    // Reset in the middle of a response, then a fresh request.
    build_req(8'h03, 1'b0);
    new_rsp(5'd3);
    send_frame(14, 1, 2);
    wait_idx(5);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk_reset("midrst");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    build_req(8'h11, 1'b0);
    new_rsp(5'd17);
    send_frame(14, 1, 2);
    wait_done(5);
    chk("t6_ok_cnt", ok_cnt, 6);
    chk("t6_loads", load_cnt, 140);
    chk("t6_left", exp_q.size(), 0);
    chk("t6_err_cnt", err_cnt, 2);

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end
endmodule
